hbmc_axi_arbiter: RTL and testbench
===================================

// Module: hbmc_axi_arbiter
// PURPOSE
//  Shares the single-beat AXI slave port of the OpenHBMC HyperRAM controller between NREQ
//  peripheral-domain requesters (e.g. TL-UL bridge, DMA). Simple valid/ready request port per
//  requester; round-robin grant; one outstanding AXI transaction at a time. Translates byte
//  addresses into the HyperRAM window and returns data/error to the granted requester.
// PARAMETERS
//  NREQ       2              number of requesters (2..8)
//  AW         32             address width, requester and AXI side
//  BASE_ADDR  32'h8000_5000  system byte address of HyperRAM offset 0
//  WIN_BYTES  32'h0080_0000  window size in bytes; must be a power of two
// PORTS
//  clk_peri_i   in   1         peripheral clock; also drives the HBMC s_axi_aclk
//  rst_peri_i   in   1         asynchronous, active-high reset
//  req_valid_i  in   NREQ      request pending, per requester
//  req_ready_o  out  NREQ      one-cycle accept pulse to the granted requester
//  req_we_i     in   NREQ      1 = write, 0 = read
//  req_addr_i   in   NREQ*AW   byte address, system map
//  req_wdata_i  in   NREQ*32   write data
//  req_wstrb_i  in   NREQ*4    byte strobes
//  rsp_valid_o  out  NREQ      one-cycle response pulse to the granted requester
//  rsp_rdata_o  out  32        read data; valid with rsp_valid_o
//  rsp_err_o    out  1         error flag; valid with rsp_valid_o
//  grant_o      out  $clog2(NREQ)  index of the current or last grant (debug)
//  busy_o       out  1         high whenever state != IDLE
//  awaddr_o/awvalid_o/awready_i, wdata_o/wstrb_o/wvalid_o/wready_i   AXI write addr/data (32b data)
//  bresp_i[2]/bvalid_i/bready_o, araddr_o/arvalid_o/arready_i        AXI write resp / read addr
//  rdata_i[32]/rresp_i[2]/rvalid_i/rready_o                          AXI read data
// BEHAVIOUR
//  Reset: every valid/ready output = 0, state IDLE, RR pointer = 0, grant_o = 0, rsp_* = 0.
//  Reset asserted mid-transaction aborts it with no response. HBMC reset must be asserted at the same time.
//  FSM states: IDLE, WR, BWAIT, RD, RWAIT, RSP.
//  IDLE: if any req_valid_i is set, pick the winner by round-robin, starting after the last grant.
//   - Latch addr, wdata, wstrb and we; pulse req_ready_o[winner].
//   - Offset = addr - BASE_ADDR. If offset >= WIN_BYTES (unsigned, includes underflow),
//     go to RSP with err = 1 and rdata = 0. No AXI traffic.
//   - Otherwise set awaddr/araddr = offset and go to WR (awvalid = wvalid = 1)
//     or RD (arvalid = 1).
//  WR: clear awvalid on awready and wvalid on wready, independently.
//   - Go to BWAIT in the cycle where both handshakes are complete. Same-cycle completion is allowed.
//  BWAIT: bready_o = 1. On bvalid: err = bresp[1]; go to RSP.
//  RD: arvalid held until arready; then go to RWAIT.
//  RWAIT: rready_o = 1. On rvalid: latch rdata; err = rresp[1]; go to RSP.
//  RSP: rsp_valid_o[grant] = 1 for exactly one cycle. No back-pressure.
//   - RR pointer advances to the grant; return to IDLE.
//  AXI valids never drop before their handshake. No new grant is issued before RSP.
//  Minimum latency, accept to rsp_valid, with zero-wait AXI: write 3 cycles, read 3 cycles,
//  out-of-window 1 cycle.
//  A requester may re-assert req_valid_i in the cycle after rsp_valid.
//  Fairness: under full load each requester is served once every NREQ transactions.
// CONFIGURATION
//  HBMC_ARB_FIXED_PRIO_EN
//   - Defined: fixed priority; the lowest index wins. RR pointer logic is removed.
//   - Undefined (default): round-robin as specified above.
// STRUCTURE
//  hbmc_arb_pkg: state enum arb_state_e, AXI response constants, localparam IDXW = $clog2(NREQ).
//  Sub-module hbmc_rr_arbiter: combinational winner select from req vector + pointer;
//  one-hot and index outputs. The FSM and pointer register stay in hbmc_axi_arbiter.
// TESTING
//  1. Write by req0 to 0x8000_5010, data 0xDEAD_BEEF, strb 0xF
//     -> awaddr 0x10, wdata 0xDEAD_BEEF; OKAY bresp -> rsp_valid[0], err 0.
//  2. Read by req1 from 0x8000_5010, HBMC returns 0xDEAD_BEEF with rresp OKAY
//     -> rsp_rdata 0xDEAD_BEEF on rsp_valid[1], err 0.
//  3. Both requesters held valid for 6 transactions -> grant order 0,1,0,1,0,1.
//     With HBMC_ARB_FIXED_PRIO_EN the order is 0,0,0,...
//  4. Read at 0x8000_4FFC and at 0x8080_5000 -> no arvalid; rsp err 1, rdata 0, one cycle after accept.
//  5. awready delayed 4 cycles while wready is immediate -> wvalid drops after 1 cycle,
//     awvalid holds 4 cycles; bresp SLVERR -> err 1.
//  6. rst_peri_i asserted while in RWAIT -> all valids 0 next edge; after release,
//     a fresh read completes normally.

Source files
------------

// File: rtl/hbmc_arb_pkg.sv
// rtl/hbmc_arb_pkg.sv - shared types and constants for the HyperRAM AXI arbiter
//
// Contents:
//   arb_state_e     transaction FSM states
//   AXI_RESP_*      AXI response encodings
//   IDXW            grant index width for the default requester count
//   resp_is_err()   true for SLVERR/DECERR
package hbmc_arb_pkg;

    localparam int NREQ_DEFAULT = 2;
    localparam int IDXW         = $clog2(NREQ_DEFAULT);

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        WR,
        BWAIT,
        RD,
        RWAIT,
        RSP
    } arb_state_e;

    function automatic logic resp_is_err(input logic [1:0] resp);
        return (resp == AXI_RESP_SLVERR) || (resp == AXI_RESP_DECERR);
    endfunction

endpackage

// File: rtl/hbmc_rr_arbiter.sv
// rtl/hbmc_rr_arbiter.sv - combinational round-robin winner select
//
// Ports:
//   req_i     in   NREQ   request vector
//   ptr_i     in   IDXW   index of the last grant; search starts at ptr_i+1
//   any_o     out  1      at least one request is pending
//   onehot_o  out  NREQ   one-hot winner (zero when any_o is low)
//   idx_o     out  IDXW   binary winner index (zero when any_o is low)
module hbmc_rr_arbiter #(
    parameter int NREQ = 2,
    parameter int IDXW = 1
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IDXW-1:0] ptr_i,
    output logic            any_o,
    output logic [NREQ-1:0] onehot_o,
    output logic [IDXW-1:0] idx_o
);

    logic [IDXW:0]   shamt;
    logic [NREQ-1:0] rot;

    // Rotate so that bit 0 of rot is requester ptr_i+1; the extra shift bit
    // keeps ptr_i+1 from wrapping when NREQ is a power of two.
    assign shamt = {1'b0, ptr_i} + 1'b1;
    assign rot   = NREQ'({req_i, req_i} >> shamt);

    always_comb begin
        int k;
        k     = 0;
        any_o = 1'b0;
        idx_o = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!any_o && rot[i]) begin
                any_o = 1'b1;
                k     = int'(ptr_i) + 1 + i;
                if (k >= NREQ) k = k - NREQ;
                idx_o = k[IDXW-1:0];
            end
        end
        onehot_o = any_o ? (NREQ'(1) << idx_o) : '0;
    end

endmodule

// File: rtl/hbmc_axi_arbiter.sv
// rtl/hbmc_axi_arbiter.sv - shares the single-beat HBMC AXI slave port between requesters
//
// One AXI transaction outstanding at a time; round-robin grant starting after
// the last grant. Addresses outside [BASE_ADDR, BASE_ADDR+WIN_BYTES) are
// answered with an error and generate no AXI traffic.
// Build option HBMC_ARB_FIXED_PRIO_EN: fixed priority, lowest index wins.
//
// Ports:
//   clk_peri_i, rst_peri_i              clock, async active-high reset
//   req_valid/we/addr/wdata/wstrb_i     per-requester request (flattened)
//   req_ready_o                         accept pulse to the winner
//   rsp_valid_o, rsp_rdata_o, rsp_err_o one-cycle response to the granted requester
//   grant_o, busy_o                     debug: current/last grant, FSM not idle
//   aw*/w*/b*/ar*/r*                    AXI master towards the HBMC
module hbmc_axi_arbiter
    import hbmc_arb_pkg::*;
#(
    parameter int            NREQ      = 2,
    parameter int            AW        = 32,
    parameter logic [AW-1:0] BASE_ADDR = AW'(32'h8000_5000),
    parameter logic [AW-1:0] WIN_BYTES = AW'(32'h0080_0000)
) (
    input  logic                     clk_peri_i,
    input  logic                     rst_peri_i,
    input  logic [NREQ-1:0]          req_valid_i,
    output logic [NREQ-1:0]          req_ready_o,
    input  logic [NREQ-1:0]          req_we_i,
    input  logic [NREQ*AW-1:0]       req_addr_i,
    input  logic [NREQ*32-1:0]       req_wdata_i,
    input  logic [NREQ*4-1:0]        req_wstrb_i,
    output logic [NREQ-1:0]          rsp_valid_o,
    output logic [31:0]              rsp_rdata_o,
    output logic                     rsp_err_o,
    output logic [$clog2(NREQ)-1:0]  grant_o,
    output logic                     busy_o,
    output logic [AW-1:0]            awaddr_o,
    output logic                     awvalid_o,
    input  logic                     awready_i,
    output logic [31:0]              wdata_o,
    output logic [3:0]               wstrb_o,
    output logic                     wvalid_o,
    input  logic                     wready_i,
    input  logic [1:0]               bresp_i,
    input  logic                     bvalid_i,
    output logic                     bready_o,
    output logic [AW-1:0]            araddr_o,
    output logic                     arvalid_o,
    input  logic                     arready_i,
    input  logic [31:0]              rdata_i,
    input  logic [1:0]               rresp_i,
    input  logic                     rvalid_i,
    output logic                     rready_o
);

    localparam int GW = $clog2(NREQ);

    arb_state_e      state_q;
    logic [GW-1:0]   grant_q;
    logic [GW-1:0]   rr_ptr;
    logic [AW-1:0]   addr_q;
    logic [31:0]     wdata_q;
    logic [3:0]      wstrb_q;
    logic [31:0]     rdata_q;
    logic            err_q;
    logic            awvalid_q;
    logic            wvalid_q;
    logic            arvalid_q;
    logic [NREQ-1:0] rsp_valid_q;

    logic            win_any_d;
    logic [NREQ-1:0] win_onehot_d;
    logic [GW-1:0]   win_idx_d;
    logic            sel_we_d;
    logic [AW-1:0]   sel_addr_d;
    logic [31:0]     sel_wdata_d;
    logic [3:0]      sel_wstrb_d;
    logic [AW-1:0]   offset_d;
    logic            in_win_d;

    hbmc_rr_arbiter #(
        .NREQ (NREQ),
        .IDXW (GW)
    ) u_rr (
        .req_i    (req_valid_i),
        .ptr_i    (rr_ptr),
        .any_o    (win_any_d),
        .onehot_o (win_onehot_d),
        .idx_o    (win_idx_d)
    );

    always_comb begin
        sel_we_d    = 1'b0;
        sel_addr_d  = '0;
        sel_wdata_d = '0;
        sel_wstrb_d = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win_onehot_d[i]) begin
                sel_we_d    = req_we_i[i];
                sel_addr_d  = req_addr_i[i*AW +: AW];
                sel_wdata_d = req_wdata_i[i*32 +: 32];
                sel_wstrb_d = req_wstrb_i[i*4 +: 4];
            end
        end
    end

    // Unsigned subtraction: addresses below BASE_ADDR wrap to huge offsets
    // and fall out of the window together with those above it.
    assign offset_d = sel_addr_d - BASE_ADDR;
    assign in_win_d = offset_d < WIN_BYTES;

`ifdef HBMC_ARB_FIXED_PRIO_EN
    // Searching "after NREQ-1" starts at index 0, i.e. lowest index wins.
    assign rr_ptr = GW'(NREQ - 1);
`else
    logic [GW-1:0] ptr_q;

    always_ff @(posedge clk_peri_i or posedge rst_peri_i) begin
        if (rst_peri_i) begin
            ptr_q <= '0;
        end else if (state_q == RSP) begin
            ptr_q <= grant_q;
        end
    end

    assign rr_ptr = ptr_q;
`endif

    always_ff @(posedge clk_peri_i or posedge rst_peri_i) begin
        if (rst_peri_i) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rsp_valid_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (win_any_d) begin
                        grant_q <= win_idx_d;
                        addr_q  <= offset_d;
                        wdata_q <= sel_wdata_d;
                        wstrb_q <= sel_wstrb_d;
                        if (!in_win_d) begin
                            err_q       <= 1'b1;
                            rdata_q     <= '0;
                            rsp_valid_q <= win_onehot_d;
                            state_q     <= RSP;
                        end else if (sel_we_d) begin
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                            state_q   <= WR;
                        end else begin
                            arvalid_q <= 1'b1;
                            state_q   <= RD;
                        end
                    end
                end
                WR: begin
                    if (awready_i) awvalid_q <= 1'b0;
                    if (wready_i)  wvalid_q  <= 1'b0;
                    // Each channel is done if already handshaken or handshaking now.
                    if ((!awvalid_q || awready_i) && (!wvalid_q || wready_i)) begin
                        state_q <= BWAIT;
                    end
                end
                BWAIT: begin
                    if (bvalid_i) begin
                        err_q       <= resp_is_err(bresp_i);
                        rdata_q     <= '0;
                        rsp_valid_q <= NREQ'(1) << grant_q;
                        state_q     <= RSP;
                    end
                end
                RD: begin
                    if (arready_i) begin
                        arvalid_q <= 1'b0;
                        state_q   <= RWAIT;
                    end
                end
                RWAIT: begin
                    if (rvalid_i) begin
                        err_q       <= resp_is_err(rresp_i);
                        rdata_q     <= rdata_i;
                        rsp_valid_q <= NREQ'(1) << grant_q;
                        state_q     <= RSP;
                    end
                end
                RSP: begin
                    rsp_valid_q <= '0;
                    state_q     <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Accept is decided in the IDLE cycle itself so that the requester sees
    // ready in the same cycle the request is latched.
    assign req_ready_o = (state_q == IDLE && !rst_peri_i) ? win_onehot_d : '0;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rdata_q;
    assign rsp_err_o   = err_q;
    assign grant_o     = grant_q;
    assign busy_o      = (state_q != IDLE);
    assign awaddr_o    = addr_q;
    assign araddr_o    = addr_q;
    assign awvalid_o   = awvalid_q;
    assign wvalid_o    = wvalid_q;
    assign wdata_o     = wdata_q;
    assign wstrb_o     = wstrb_q;
    assign arvalid_o   = arvalid_q;
    assign bready_o    = (state_q == BWAIT);
    assign rready_o    = (state_q == RWAIT);

endmodule

// File: tb/tb_hbmc_axi_arbiter.sv
// tb/tb_hbmc_axi_arbiter.sv - scoreboard bench for hbmc_axi_arbiter
module tb_hbmc_axi_arbiter;

    typedef struct {
        int          req;
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } rsp_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } axi_t;

    logic        clk;
    logic        rst;
    logic        r_valid [2];
    logic        r_we    [2];
    logic [31:0] r_addr  [2];
    logic [31:0] r_wdata [2];
    logic [3:0]  r_wstrb [2];

    logic [1:0]  req_valid, req_ready, req_we, rsp_valid;
    logic [63:0] req_addr, req_wdata;
    logic [7:0]  req_wstrb;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [0:0]  grant;
    logic        busy;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [3:0]  wstrb;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [1:0]  bresp, rresp;

    assign req_valid = {r_valid[1], r_valid[0]};
    assign req_we    = {r_we[1], r_we[0]};
    assign req_addr  = {r_addr[1], r_addr[0]};
    assign req_wdata = {r_wdata[1], r_wdata[0]};
    assign req_wstrb = {r_wstrb[1], r_wstrb[0]};

    hbmc_axi_arbiter dut (
        .clk_peri_i  (clk),
        .rst_peri_i  (rst),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_we_i    (req_we),
        .req_addr_i  (req_addr),
        .req_wdata_i (req_wdata),
        .req_wstrb_i (req_wstrb),
        .rsp_valid_o (rsp_valid),
        .rsp_rdata_o (rsp_rdata),
        .rsp_err_o   (rsp_err),
        .grant_o     (grant),
        .busy_o      (busy),
        .awaddr_o    (awaddr),
        .awvalid_o   (awvalid),
        .awready_i   (awready),
        .wdata_o     (wdata),
        .wstrb_o     (wstrb),
        .wvalid_o    (wvalid),
        .wready_i    (wready),
        .bresp_i     (bresp),
        .bvalid_i    (bvalid),
        .bready_o    (bready),
        .araddr_o    (araddr),
        .arvalid_o   (arvalid),
        .arready_i   (arready),
        .rdata_i     (rdata),
        .rresp_i     (rresp),
        .rvalid_i    (rvalid),
        .rready_o    (rready)
    );

    int   n_vec = 0;
    int   n_bad = 0;
    int   cyc   = 0;
    int   acc_cyc [2];
    rsp_t rsp_q[$];
    axi_t axi_q[$];

    // HBMC model knobs
    int          aw_delay   = 0;
    logic [1:0]  b_resp_cfg = 2'b00;
    logic [31:0] r_data_cfg = 32'h0;
    logic [1:0]  r_resp_cfg = 2'b00;
    bit          r_hold     = 0;
    int          aw_hi      = 0;
    int          w_hi       = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // HBMC slave model: decides readies/valids at the negedge for the next posedge.
    initial begin
        int  aw_cnt;
        bit  aw_seen, w_seen, b_pend, r_pend;
        aw_cnt = 0; aw_seen = 0; w_seen = 0; b_pend = 0; r_pend = 0;
        awready = 0; wready = 0; bvalid = 0; bresp = 0;
        arready = 0; rvalid = 0; rdata = 0; rresp = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0;
                aw_cnt = 0; aw_seen = 0; w_seen = 0; b_pend = 0; r_pend = 0;
                continue;
            end
            if (awvalid) aw_hi++;
            if (wvalid)  w_hi++;
            bvalid = b_pend;
            bresp  = b_resp_cfg;
            if (bvalid && bready) b_pend = 0;
            rvalid = r_pend && !r_hold;
            rdata  = rvalid ? r_data_cfg : 32'h0;
            rresp  = r_resp_cfg;
            if (rvalid && rready) r_pend = 0;

            awready = awvalid && (aw_cnt >= aw_delay);
            if (awvalid && !awready) aw_cnt++;
            if (awvalid && awready) begin
                aw_cnt = 0;
                aw_seen = 1;
                if (axi_q.size() == 0) check("axi_unexpected_aw", 32'd1, 32'd0);
                else begin
                    check("awaddr", awaddr, axi_q[0].addr);
                    check("aw_is_write", 32'(axi_q[0].we), 32'd1);
                end
            end
            wready = wvalid;
            if (wvalid) begin
                w_seen = 1;
                if (axi_q.size() == 0) check("axi_unexpected_w", 32'd1, 32'd0);
                else begin
                    check("wdata", wdata, axi_q[0].wdata);
                    check("wstrb", 32'(wstrb), 32'(axi_q[0].wstrb));
                end
            end
            if (aw_seen && w_seen) begin
                b_pend = 1; aw_seen = 0; w_seen = 0;
                if (axi_q.size() != 0) void'(axi_q.pop_front());
            end
            arready = arvalid;
            if (arvalid) begin
                r_pend = 1;
                if (axi_q.size() == 0) check("axi_unexpected_ar", 32'd1, 32'd0);
                else begin
                    check("araddr", araddr, axi_q[0].addr);
                    check("ar_is_read", 32'(axi_q[0].we), 32'd0);
                    void'(axi_q.pop_front());
                end
            end
        end
    end

    // Response monitor
    initial begin
        rsp_t e;
        forever begin
            @(negedge clk);
            if (rst || rsp_valid == 2'b00) continue;
            if (rsp_q.size() == 0) begin
                check("rsp_unexpected", 32'(rsp_valid), 32'd0);
                continue;
            end
            e = rsp_q.pop_front();
            check("rsp_who", 32'(rsp_valid), 32'(1 << e.req));
            check("rsp_rdata", rsp_rdata, e.rdata);
            check("rsp_err", 32'(rsp_err), 32'(e.err));
            if (e.lat >= 0) check("rsp_latency", 32'(cyc - acc_cyc[e.req]), 32'(e.lat));
        end
    end

    task automatic issue(input int r, input logic we, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] s);
        int n;
        n = 0;
        @(posedge clk); #1;
        r_valid[r] = 1'b1; r_we[r] = we; r_addr[r] = a; r_wdata[r] = d; r_wstrb[r] = s;
        do begin
            @(negedge clk);
            n++;
        end while (!req_ready[r] && n < 300);
        if (!req_ready[r]) check("accept_timeout", 32'd0, 32'd1);
        acc_cyc[r] = cyc;
        @(posedge clk); #1;
        r_valid[r] = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((rsp_q.size() != 0 || axi_q.size() != 0 || busy) && n < 300);
        if (n >= 300) check("drain_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            r_valid[i] = 0; r_we[i] = 0; r_addr[i] = 0; r_wdata[i] = 0; r_wstrb[i] = 0;
            acc_cyc[i] = 0;
        end
        rst = 1'b1;
        r_valid[0] = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_handshakes",
              32'({awvalid, wvalid, arvalid, bready, rready, busy, rsp_valid, req_ready}), 32'd0);
        check("reset_grant", 32'(grant), 32'd0);
        check("reset_rsp", {rsp_rdata[30:0], rsp_err}, 32'd0);
        r_valid[0] = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;

        // 1: write by req0
        axi_q.push_back('{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF});
        rsp_q.push_back('{0, 32'h0, 1'b0, 3});
        issue(0, 1'b1, 32'h8000_5010, 32'hDEAD_BEEF, 4'hF);
        wait_done();

        // 2: read by req1
        r_data_cfg = 32'hDEAD_BEEF;
        axi_q.push_back('{1'b0, 32'h0000_0010, 32'h0, 4'h0});
        rsp_q.push_back('{1, 32'hDEAD_BEEF, 1'b0, 3});
        issue(1, 1'b0, 32'h8000_5010, 32'h0, 4'h0);
        wait_done();
        check("grant_after_req1", 32'(grant), 32'd1);

        // 3: both requesters loaded, expect 0,1,0,1,0,1
        for (int k = 0; k < 6; k++) begin
            axi_q.push_back('{1'b1, 32'((k % 2) * 32'h100 + (k / 2) * 4),
                              32'hA000_0000 + 32'((k % 2) * 16 + k / 2), 4'hF});
            rsp_q.push_back('{k % 2, 32'h0, 1'b0, -1});
        end
        fork
            for (int j = 0; j < 3; j++)
                issue(0, 1'b1, 32'h8000_5000 + 32'(j * 4), 32'hA000_0000 + 32'(j), 4'hF);
            for (int j = 0; j < 3; j++)
                issue(1, 1'b1, 32'h8000_5100 + 32'(j * 4), 32'hA000_0010 + 32'(j), 4'hF);
        join
        wait_done();

        // 4: last in-window word, then both out-of-window edges
        r_data_cfg = 32'h1234_5678;
        axi_q.push_back('{1'b0, 32'h007F_FFFC, 32'h0, 4'h0});
        rsp_q.push_back('{0, 32'h1234_5678, 1'b0, 3});
        issue(0, 1'b0, 32'h8080_4FFC, 32'h0, 4'h0);
        wait_done();
        rsp_q.push_back('{0, 32'h0, 1'b1, 1});
        issue(0, 1'b0, 32'h8000_4FFC, 32'h0, 4'h0);
        wait_done();
        rsp_q.push_back('{1, 32'h0, 1'b1, 1});
        issue(1, 1'b0, 32'h8080_5000, 32'h0, 4'h0);
        wait_done();

        // 5: awready late, wready immediate, SLVERR
        aw_delay = 3; b_resp_cfg = 2'b10; aw_hi = 0; w_hi = 0;
        axi_q.push_back('{1'b1, 32'h0000_0020, 32'hCAFE_F00D, 4'h3});
        rsp_q.push_back('{1, 32'h0, 1'b1, 6});
        issue(1, 1'b1, 32'h8000_5020, 32'hCAFE_F00D, 4'h3);
        wait_done();
        check("awvalid_cycles", 32'(aw_hi), 32'd4);
        check("wvalid_cycles", 32'(w_hi), 32'd1);
        aw_delay = 0; b_resp_cfg = 2'b00;

        // 6: reset while waiting for read data
        r_hold = 1;
        axi_q.push_back('{1'b0, 32'h0000_0040, 32'h0, 4'h0});
        issue(0, 1'b0, 32'h8000_5040, 32'h0, 4'h0);
        for (int n = 0; n < 20 && !rready; n++) @(negedge clk);
        check("rwait_reached", 32'(rready), 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("midrst_handshakes",
              32'({awvalid, wvalid, arvalid, bready, rready, busy, rsp_valid, req_ready}), 32'd0);
        check("midrst_grant", 32'(grant), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        r_hold = 0;
        // pointer back to 0 after reset: requester 1 must win first
        r_data_cfg = 32'h0BAD_F00D;
        axi_q.push_back('{1'b0, 32'h0000_0044, 32'h0, 4'h0});
        axi_q.push_back('{1'b0, 32'h0000_0048, 32'h0, 4'h0});
        rsp_q.push_back('{1, 32'h0BAD_F00D, 1'b0, 3});
        rsp_q.push_back('{0, 32'h0BAD_F00D, 1'b0, -1});
        fork
            issue(1, 1'b0, 32'h8000_5044, 32'h0, 4'h0);
            issue(0, 1'b0, 32'h8000_5048, 32'h0, 4'h0);
        join
        wait_done();
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
